serdes_tx_pipeline: RTL and testbench

Transmit-side PHY serializer. It accepts 130-bit PCS words (128b/130b encoded) over a valid/ready handshake, buffers one word, and shifts each word out MSB-first on a continuous one-bit-per-clock serial stream. After enable, it sends a fixed training sequence so the far-end receiver can achieve CDR lock and deskew. Once in data mode, any word slot with no buffered data is filled with an all-zero idle word.

---
 rtl/serdes_tx_pipeline.sv | 155 +++++++++++++++
 tb/tb_serdes_tx_pipeline.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_tx_pipeline.sv
// 128b/130b transmit serializer: one-word hold buffer, training preamble after each enable,
// MSB-first shift-out with all-zero idle words filling any slot that has no user data.
module serdes_tx_pipeline #(
    parameter int                 P_WIDTH       = 130,
    parameter int                 TRAIN_WORDS   = 4,
    parameter logic [P_WIDTH-1:0] TRAIN_PATTERN = {65{2'b10}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tx_en,
    input  logic [P_WIDTH-1:0] parallel_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               serial_out,
    output logic               train_done,
    output logic               tx_active,
    output logic               underrun,
    output logic [1:0]         dbg_state
);
    localparam int CNT_W = $clog2(P_WIDTH);
    localparam int TC_W  = $clog2(TRAIN_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(P_WIDTH - 1);
    localparam logic [TC_W-1:0]  LAST_TRAIN = TC_W'(TRAIN_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRAIN = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [P_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [TC_W-1:0]    r_train_cnt, w_train_cnt_nxt;
    logic [P_WIDTH-1:0] r_hold, w_hold_nxt;
    logic               r_hold_valid, w_hold_valid_nxt;
    logic               r_stop, w_stop_nxt;
    logic               r_train_done, w_train_done_nxt;
    logic               r_tx_active, w_tx_active_nxt;
    logic               r_underrun, w_underrun_nxt;

    logic w_boundary;
    logic w_in_ready;
    logic w_accept;

    // in_valid/in_ready: a word transfers on every posedge where both are high. in_ready
    // is a function of registers only, and in_valid may not be withdrawn by the sender.
    assign w_in_ready = !r_hold_valid && (r_state == S_TRAIN || r_state == S_DATA);
    assign w_accept   = in_valid && w_in_ready;
    assign w_boundary = (r_bit_cnt == LAST_BIT);

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_train_cnt_nxt  = r_train_cnt;
        w_hold_nxt       = r_hold;
        w_hold_valid_nxt = r_hold_valid;
        w_stop_nxt       = r_stop;
        w_train_done_nxt = r_train_done;
        w_tx_active_nxt  = r_tx_active;
        w_underrun_nxt   = 1'b0;

        if (w_accept) begin
            w_hold_nxt       = parallel_in;
            w_hold_valid_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_shift_nxt   = '0;
                w_bit_cnt_nxt = '0;
                if (tx_en) begin
                    w_state_nxt     = S_TRAIN;
                    w_shift_nxt     = TRAIN_PATTERN;
                    w_train_cnt_nxt = '0;
                    w_stop_nxt      = 1'b0;
                end
            end
            S_TRAIN, S_DATA: begin
                w_shift_nxt   = {r_shift[P_WIDTH-2:0], 1'b0};
                w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                // A disable request is remembered so the current word always completes.
                if (!tx_en) begin
                    w_stop_nxt = 1'b1;
                end
                if (w_boundary) begin
                    w_bit_cnt_nxt = '0;
                    if (r_stop || !tx_en) begin
                        w_state_nxt      = S_IDLE;
                        w_shift_nxt      = '0;
                        w_train_done_nxt = 1'b0;
                        w_tx_active_nxt  = 1'b0;
                        w_stop_nxt       = 1'b0;
                    end else if (r_state == S_TRAIN && r_train_cnt < LAST_TRAIN) begin
                        w_train_cnt_nxt = r_train_cnt + TC_W'(1);
                        w_shift_nxt     = TRAIN_PATTERN;
                    end else begin
                        if (r_state == S_TRAIN) begin
                            w_train_cnt_nxt  = r_train_cnt + TC_W'(1);
                            w_state_nxt      = S_DATA;
                            w_train_done_nxt = 1'b1;
                        end
                        if (r_hold_valid) begin
                            w_shift_nxt      = r_hold;
                            w_hold_valid_nxt = 1'b0;
                            w_tx_active_nxt  = 1'b1;
                        end else begin
                            w_shift_nxt     = '0;
                            w_tx_active_nxt = 1'b0;
                            w_underrun_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_train_cnt  <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_stop       <= 1'b0;
            r_train_done <= 1'b0;
            r_tx_active  <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_train_cnt  <= w_train_cnt_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_stop       <= w_stop_nxt;
            r_train_done <= w_train_done_nxt;
            r_tx_active  <= w_tx_active_nxt;
            r_underrun   <= w_underrun_nxt;
        end
    end

    assign serial_out = r_shift[P_WIDTH-1];
    assign in_ready   = w_in_ready;
    assign train_done = r_train_done;
    assign tx_active  = r_tx_active;
    assign underrun   = r_underrun;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_serdes_tx_pipeline.sv
// Bench for serdes_tx_pipeline: a word-slot/bit-queue model of the serial stream checked
// every cycle, plus scenario tasks with explicit expectations for each feature.
module tb_serdes_tx_pipeline;
    localparam int W  = 130;
    localparam int TW = 4;
    localparam logic [W-1:0] TRAIN_PAT = {65{2'b10}};

    logic         clk;
    logic         rst_n;
    logic         tx_en;
    logic [W-1:0] parallel_in;
    logic         in_valid;
    logic         in_ready;
    logic         serial_out;
    logic         train_done;
    logic         tx_active;
    logic         underrun;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int failures = 0;

    serdes_tx_pipeline dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .parallel_in(parallel_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .serial_out (serial_out),
        .train_done (train_done),
        .tx_active  (tx_active),
        .underrun   (underrun),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // The line is a sequence of word slots: TW training slots after enable, then one slot
    // per word carrying the held user word or zeros. bit_q holds the bits still to be sent.
    logic         bit_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_hold = '0;
    logic         m_hold_valid = 1'b0;
    logic         m_running = 1'b0;
    logic         m_stop = 1'b0;
    logic         m_train_done = 1'b0;
    logic         m_tx_active = 1'b0;
    logic         m_underrun = 1'b0;
    logic         m_acc;
    int           slot_no = 0;
    logic [4:0]   m_vec = '0;  // {serial_out, in_ready, train_done, tx_active, underrun}

    function automatic void push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) bit_q.push_back(w[i]);
    endfunction

    always @(posedge clk) begin
        m_acc = in_valid && !m_hold_valid && m_running;
        m_underrun = 1'b0;
        if (!rst_n) begin
            bit_q.delete();
            m_running = 1'b0; m_stop = 1'b0; m_hold_valid = 1'b0;
            m_train_done = 1'b0; m_tx_active = 1'b0; slot_no = 0;
        end else begin
            if (!m_running) begin
                if (tx_en) begin
                    m_running = 1'b1; m_stop = 1'b0; slot_no = 0;
                    push_word(TRAIN_PAT);
                end
            end else begin
                if (!tx_en) m_stop = 1'b1;
                bit_q.delete(0);
                if (bit_q.size() == 0) begin
                    if (m_stop) begin
                        m_running = 1'b0; m_stop = 1'b0;
                        m_train_done = 1'b0; m_tx_active = 1'b0;
                    end else begin
                        slot_no++;
                        if (slot_no < TW) begin
                            push_word(TRAIN_PAT);
                        end else begin
                            m_train_done = 1'b1;
                            if (m_hold_valid) begin
                                push_word(m_hold); m_hold_valid = 1'b0; m_tx_active = 1'b1;
                            end else begin
                                push_word('0); m_tx_active = 1'b0; m_underrun = 1'b1;
                            end
                        end
                    end
                end
            end
            if (m_acc) begin
                m_hold = parallel_in; m_hold_valid = 1'b1;
            end
        end
        m_vec = {(bit_q.size() != 0) ? bit_q[0] : 1'b0, !m_hold_valid && m_running,
                 m_train_done, m_tx_active, m_underrun};
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < 5; i++) w = (w << 32) | W'($urandom());
        return w;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; tx_en = 1'b0; in_valid = 1'b0; parallel_in = '0;
        tick(); tick();
        checks++;
        if ({serial_out, in_ready, train_done, tx_active, underrun} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000",
                     {serial_out, in_ready, train_done, tx_active, underrun});
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if ({serial_out, in_ready, train_done, tx_active, underrun} !== m_vec ||
                m_vec !== 5'b0) begin
                failures++;
                $display("FAIL idle_after_reset got=%b exp=00000",
                         {serial_out, in_ready, train_done, tx_active, underrun});
            end
        end
    endtask

    task automatic test_training();
        tx_en = 1'b1;
        for (int c = 0; c < TW * W; c++) begin
            tick();
            checks++;
            if (serial_out !== ((c % 2) == 0) || in_ready !== 1'b1 ||
                train_done !== 1'b0 || tx_active !== 1'b0) begin
                failures++;
                $display("FAIL training_bit c=%0d got s=%b r=%b td=%b ta=%b exp s=%b r=1 td=0 ta=0",
                         c, serial_out, in_ready, train_done, tx_active, (c % 2) == 0);
            end
            checks++;
            if ({serial_out, in_ready, train_done, tx_active, underrun} !== m_vec) begin
                failures++;
                $display("FAIL model_training c=%0d got=%b exp=%b", c,
                         {serial_out, in_ready, train_done, tx_active, underrun}, m_vec);
            end
        end
    endtask

    task automatic test_idle_fill();
        int pulses = 0;
        int pos[$];
        in_valid = 1'b0;
        for (int k = 0; k < 3 * W; k++) begin
            tick();
            if (underrun === 1'b1) begin pulses++; pos.push_back(k); end
            checks++;
            if (serial_out !== 1'b0 || tx_active !== 1'b0 || train_done !== 1'b1) begin
                failures++;
                $display("FAIL idle_slot k=%0d got s=%b ta=%b td=%b exp s=0 ta=0 td=1",
                         k, serial_out, tx_active, train_done);
            end
            checks++;
            if ({serial_out, in_ready, train_done, tx_active, underrun} !== m_vec) begin
                failures++;
                $display("FAIL model_idle k=%0d got=%b exp=%b", k,
                         {serial_out, in_ready, train_done, tx_active, underrun}, m_vec);
            end
        end
        checks++;
        if (pulses != 3 || pos.size() != 3 || pos[0] != 0 || pos[1] != W || pos[2] != 2 * W) begin
            failures++;
            $display("FAIL underrun_pulses got=%0d pulses exp=3 at 0,130,260", pulses);
        end
    endtask

    task automatic test_data_word();
        logic [W-1:0] w;
        logic [W-1:0] rx;
        int n;
        w = '0; w[W-1] = 1'b1; rx = '0;
        in_valid = 1'b1; parallel_in = w;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (tx_active !== 1'b1 && n < 400) begin
            checks++;
            if ({serial_out, in_ready, train_done, tx_active, underrun} !== m_vec) begin
                failures++;
                $display("FAIL model_latency n=%0d got=%b exp=%b", n,
                         {serial_out, in_ready, train_done, tx_active, underrun}, m_vec);
            end
            tick(); n++;
        end
        checks++;
        if (n != W + 1) begin
            failures++; $display("FAIL worst_latency got=%0d exp=%0d", n, W + 1);
        end
        for (int b = 0; b < W; b++) begin
            if (b > 0) tick();
            rx = {rx[W-2:0], serial_out};
            checks++;
            if (serial_out !== (b == 0) || tx_active !== 1'b1 || underrun !== 1'b0) begin
                failures++;
                $display("FAIL msb_word b=%0d got s=%b ta=%b u=%b exp s=%b ta=1 u=0",
                         b, serial_out, tx_active, underrun, b == 0);
            end
            checks++;
            if ({serial_out, in_ready, train_done, tx_active, underrun} !== m_vec) begin
                failures++;
                $display("FAIL model_msb_word b=%0d got=%b exp=%b", b,
                         {serial_out, in_ready, train_done, tx_active, underrun}, m_vec);
            end
        end
        checks++;
        if (rx !== w) begin
            failures++; $display("FAIL deser_msb_word got=%h exp=%h", rx, w);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[4];
        logic [W-1:0] rx;
        logic [W-1:0] e;
        int accepts = 0, rx_bits = 0, rx_words = 0, urun = 0, act = 0, rdy = 0;
        logic fire;
        for (int i = 0; i < 4; i++) words[i] = rand_word();
        rx = '0;
        in_valid = 1'b1; parallel_in = words[0];
        for (int t = 1; t <= 5 * W; t++) begin
            fire = in_valid && m_vec[3];
            tick();
            if (in_ready === 1'b1 && in_valid) rdy++;
            if (fire) begin
                exp_q.push_back(parallel_in);
                accepts++;
                if (accepts < 4) parallel_in = words[accepts];
                else in_valid = 1'b0;
            end
            if (underrun === 1'b1) urun++;
            if (tx_active === 1'b1) begin
                act++;
                rx = {rx[W-2:0], serial_out};
                rx_bits++;
                if (rx_bits == W) begin
                    rx_bits = 0; rx_words++;
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                    checks++;
                    if (rx !== e) begin
                        failures++; $display("FAIL b2b_word n=%0d got=%h exp=%h", rx_words, rx, e);
                    end
                end
            end
            checks++;
            if ({serial_out, in_ready, train_done, tx_active, underrun} !== m_vec) begin
                failures++;
                $display("FAIL model_b2b t=%0d got=%b exp=%b", t,
                         {serial_out, in_ready, train_done, tx_active, underrun}, m_vec);
            end
        end
        checks++;
        if (accepts != 4 || rx_words != 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_counts got acc=%0d rx=%0d left=%0d exp 4 4 0",
                     accepts, rx_words, exp_q.size());
        end
        checks++;
        if (urun != 1 || act != 4 * W || rdy != 3) begin
            failures++;
            $display("FAIL b2b_gapless got urun=%0d act=%0d rdy=%0d exp 1 520 3", urun, act, rdy);
        end
    endtask

    task automatic test_disable_reenable();
        logic [W-1:0] wa, wb, rx;
        int n;
        wa = rand_word(); wb = rand_word(); rx = '0;
        in_valid = 1'b1; parallel_in = wa;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (tx_active !== 1'b1 && n < 300) begin tick(); n++; end
        checks++;
        if (n >= 300) begin failures++; $display("FAIL dis_wait_word got=timeout exp=tx_active"); end
        in_valid = 1'b1; parallel_in = wb;
        tick();
        in_valid = 1'b0;
        repeat (49) tick();
        tx_en = 1'b0;
        tick();
        tx_en = 1'b1;
        for (int k = 51; k < W; k++) begin
            if (k > 51) tick();
            checks++;
            if (serial_out !== wa[W-1-k] || train_done !== 1'b1 || tx_active !== 1'b1) begin
                failures++;
                $display("FAIL dis_tail k=%0d got s=%b td=%b ta=%b exp s=%b td=1 ta=1",
                         k, serial_out, train_done, tx_active, wa[W-1-k]);
            end
            checks++;
            if ({serial_out, in_ready, train_done, tx_active, underrun} !== m_vec) begin
                failures++;
                $display("FAIL model_dis_tail k=%0d got=%b exp=%b", k,
                         {serial_out, in_ready, train_done, tx_active, underrun}, m_vec);
            end
        end
        tick();
        checks++;
        if ({serial_out, in_ready, train_done, tx_active, underrun} !== 5'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL dis_idle got=%b st=%0d exp=00000 st=0",
                     {serial_out, in_ready, train_done, tx_active, underrun}, dbg_state);
        end
        for (int c = 0; c < TW * W; c++) begin
            tick();
            checks++;
            if (serial_out !== ((c % 2) == 0) || tx_active !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL retrain c=%0d got s=%b ta=%b r=%b exp s=%b ta=0 r=0",
                         c, serial_out, tx_active, in_ready, (c % 2) == 0);
            end
        end
        for (int b = 0; b < W; b++) begin
            tick();
            rx = {rx[W-2:0], serial_out};
            checks++;
            if (tx_active !== 1'b1 || underrun !== 1'b0 || train_done !== 1'b1) begin
                failures++;
                $display("FAIL held_word_slot b=%0d got ta=%b u=%b td=%b exp 1 0 1",
                         b, tx_active, underrun, train_done);
            end
            checks++;
            if ({serial_out, in_ready, train_done, tx_active, underrun} !== m_vec) begin
                failures++;
                $display("FAIL model_held b=%0d got=%b exp=%b", b,
                         {serial_out, in_ready, train_done, tx_active, underrun}, m_vec);
            end
        end
        checks++;
        if (rx !== wb) begin failures++; $display("FAIL held_word got=%h exp=%h", rx, wb); end
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] wc, wd;
        int n;
        wc = rand_word(); wd = rand_word();
        in_valid = 1'b1; parallel_in = wc;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (tx_active !== 1'b1 && n < 300) begin tick(); n++; end
        checks++;
        if (n >= 300) begin failures++; $display("FAIL rst_wait_word got=timeout exp=tx_active"); end
        in_valid = 1'b1; parallel_in = wd;
        tick();
        in_valid = 1'b0;
        repeat (69) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({serial_out, in_ready, train_done, tx_active, underrun} !== 5'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL mid_word_reset got=%b st=%0d exp=00000 st=0",
                     {serial_out, in_ready, train_done, tx_active, underrun}, dbg_state);
        end
        rst_n = 1'b1;
        for (int c = 0; c < TW * W; c++) begin
            tick();
            checks++;
            if (serial_out !== ((c % 2) == 0) || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL rst_retrain c=%0d got s=%b r=%b exp s=%b r=1",
                         c, serial_out, in_ready, (c % 2) == 0);
            end
        end
        for (int s = 0; s < W; s++) begin
            tick();
            checks++;
            if (serial_out !== 1'b0 || tx_active !== 1'b0 || underrun !== (s == 0)) begin
                failures++;
                $display("FAIL dropped_hold s=%0d got s=%b ta=%b u=%b exp s=0 ta=0 u=%b",
                         s, serial_out, tx_active, underrun, s == 0);
            end
            checks++;
            if ({serial_out, in_ready, train_done, tx_active, underrun} !== m_vec) begin
                failures++;
                $display("FAIL model_after_rst s=%0d got=%b exp=%b", s,
                         {serial_out, in_ready, train_done, tx_active, underrun}, m_vec);
            end
        end
        tx_en = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0; tx_en = 1'b0; in_valid = 1'b0; parallel_in = '0;
        test_reset();
        test_training();
        test_idle_fill();
        test_data_word();
        test_back_to_back();
        test_disable_reenable();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
